// File: rtl/instruction_c_aligner.sv
// Fetch-side RV32C aligner: takes word-aligned fetch data and issues one 16/32-bit instruction
// per handshake. Compressed support (halfword buffer, SKIP/HALF states) needs ALIGNER_RVC_EN.
module instruction_c_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iFLUSH,
   input  logic [31:0] iFLUSH_PC,
   output logic [31:0] oFETCH_ADDR,
   output logic        oFETCH_READY,
   input  logic        iFETCH_VALID,
   input  logic [31:0] iFETCH_DATA,
   output logic        oIR_VALID,
   input  logic        iIR_READY,
   output logic [31:0] oIR,
   output logic [31:0] oIR_PC,
   output logic        oIR_C
);

   localparam logic [31:0] WordMask  = 32'hFFFF_FFFC;
   localparam logic [31:0] ResetAddr = RESET_PC & WordMask;

   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic        ir_valid_q, ir_valid_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ir_pc_q, ir_pc_d;
   logic        adv;
   logic        fetch_ready;
   logic        xfer;
   logic [31:0] flush_addr;

   assign adv        = !ir_valid_q || iIR_READY;
   assign flush_addr = iFLUSH_PC & WordMask;
   assign xfer       = fetch_ready && iFETCH_VALID;

`ifdef ALIGNER_RVC_EN
   typedef enum logic [1:0] {StEmpty, StSkip, StHalfU, StHalfC} state_e;

   localparam state_e ResetState = RESET_PC[1] ? StSkip : StEmpty;

   state_e      state_q, state_d;
   logic [15:0] hb_q, hb_d;
   logic [31:0] hb_pc_q, hb_pc_d;
   logic        ir_c_q, ir_c_d;
   logic [15:0] lo_half, hi_half;
   logic        lo_c, hi_c;

   assign lo_half = iFETCH_DATA[15:0];
   assign hi_half = iFETCH_DATA[31:16];
   assign lo_c    = lo_half[1:0] != 2'b11;
   assign hi_c    = hi_half[1:0] != 2'b11;

   // SKIP never holds an instruction, so it may fetch regardless of output backpressure.
   assign fetch_ready = !iFLUSH && (state_q != StHalfC) && ((state_q == StSkip) || adv);

   always_comb begin
      state_d      = state_q;
      hb_d         = hb_q;
      hb_pc_d      = hb_pc_q;
      fetch_addr_d = fetch_addr_q;
      ir_valid_d   = ir_valid_q && !iIR_READY;
      ir_d         = ir_q;
      ir_pc_d      = ir_pc_q;
      ir_c_d       = ir_c_q;
      if (iFLUSH) begin
         ir_valid_d   = 1'b0;
         fetch_addr_d = flush_addr;
         state_d      = iFLUSH_PC[1] ? StSkip : StEmpty;
      end else begin
         if (xfer) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
         end
         case (state_q)
            StEmpty: begin
               if (xfer) begin
                  ir_valid_d = 1'b1;
                  ir_pc_d    = fetch_addr_q;
                  if (lo_c) begin
                     ir_d    = {16'h0000, lo_half};
                     ir_c_d  = 1'b1;
                     hb_d    = hi_half;
                     hb_pc_d = fetch_addr_q + 32'd2;
                     state_d = hi_c ? StHalfC : StHalfU;
                  end else begin
                     ir_d   = iFETCH_DATA;
                     ir_c_d = 1'b0;
                  end
               end
            end
            StSkip: begin
               if (xfer) begin
                  hb_d    = hi_half;
                  hb_pc_d = fetch_addr_q + 32'd2;
                  state_d = hi_c ? StHalfC : StHalfU;
               end
            end
            StHalfU: begin
               if (xfer) begin
                  ir_valid_d = 1'b1;
                  ir_d       = {lo_half, hb_q};
                  ir_pc_d    = hb_pc_q;
                  ir_c_d     = 1'b0;
                  hb_d       = hi_half;
                  hb_pc_d    = fetch_addr_q + 32'd2;
                  state_d    = hi_c ? StHalfC : StHalfU;
               end
            end
            StHalfC: begin
               if (adv) begin
                  ir_valid_d = 1'b1;
                  ir_d       = {16'h0000, hb_q};
                  ir_pc_d    = hb_pc_q;
                  ir_c_d     = 1'b1;
                  state_d    = StEmpty;
               end
            end
            default: state_d = ResetState;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ResetState;
         hb_q    <= 16'h0000;
         hb_pc_q <= 32'h0000_0000;
         ir_c_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hb_q    <= hb_d;
         hb_pc_q <= hb_pc_d;
         ir_c_q  <= ir_c_d;
      end
   end

   assign oIR_C = ir_c_q;
`else
   assign fetch_ready = !iFLUSH && adv;

   always_comb begin
      fetch_addr_d = fetch_addr_q;
      ir_valid_d   = ir_valid_q && !iIR_READY;
      ir_d         = ir_q;
      ir_pc_d      = ir_pc_q;
      if (iFLUSH) begin
         ir_valid_d   = 1'b0;
         fetch_addr_d = flush_addr;
      end else if (xfer) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
         ir_valid_d   = 1'b1;
         ir_d         = iFETCH_DATA;
         ir_pc_d      = fetch_addr_q;
      end
   end

   assign oIR_C = 1'b0;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         fetch_addr_q <= ResetAddr;
         ir_valid_q   <= 1'b0;
         ir_q         <= 32'h0000_0000;
         ir_pc_q      <= 32'h0000_0000;
      end else begin
         fetch_addr_q <= fetch_addr_d;
         ir_valid_q   <= ir_valid_d;
         ir_q         <= ir_d;
         ir_pc_q      <= ir_pc_d;
      end
   end

   assign oFETCH_ADDR  = fetch_addr_q;
   assign oFETCH_READY = fetch_ready;
   assign oIR_VALID    = ir_valid_q;
   assign oIR          = ir_q;
   assign oIR_PC       = ir_pc_q;

endmodule
